// File: rtl/bus_frame_receiver.sv
// Serial frame receiver for the shared FPGA bus: deserialises start/src/dst/data/crc/stop frames,
// checks the x^4+x+1 CRC and filters by destination address.
module bus_frame_receiver #(
    parameter logic [3:0] MY_ADDR    = 4'd1,
    parameter logic [3:0] BCAST_ADDR = 4'd15,
    parameter int         DATA_W     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_in,
    output logic              rx_valid,
    output logic [3:0]        rx_src,
    output logic [DATA_W-1:0] rx_data,
    output logic              crc_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SRC     = 3'd1,
        DST     = 3'd2,
        DATA    = 3'd3,
        CRC     = 3'd4,
        STOP    = 3'd5,
        WAIT_HI = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         src_r;
    logic [3:0]         dst_r;
    logic [DATA_W-1:0]  data_r;
    logic [3:0]         crc_r;
    logic [3:0]         crc_rx_r;
    logic               stop_r;
    logic               eval_r;
    logic               valid_nxt_s;
    logic               crc_err_nxt_s;
    logic               frame_err_nxt_s;
    logic               busy_nxt_s;
    logic               rx_valid_r;
    logic [3:0]         rx_src_r;
    logic [DATA_W-1:0]  rx_data_r;
    logic               crc_err_r;
    logic               frame_err_r;
    logic               busy_r;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the field counter hitting zero marks the last bit of a field
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (!bus_in) state_nxt_s = SRC;  else state_nxt_s = IDLE;
            SRC:     if (cnt_r == '0) state_nxt_s = DST;  else state_nxt_s = SRC;
            DST:     if (cnt_r == '0) state_nxt_s = DATA; else state_nxt_s = DST;
            DATA:    if (cnt_r == '0) state_nxt_s = CRC;  else state_nxt_s = DATA;
            CRC:     if (cnt_r == '0) state_nxt_s = STOP; else state_nxt_s = CRC;
            STOP:    if (bus_in) state_nxt_s = IDLE;  else state_nxt_s = WAIT_HI;
            WAIT_HI: if (bus_in) state_nxt_s = IDLE;  else state_nxt_s = WAIT_HI;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Verdict on the frame whose stop bit was captured on the previous edge
    always_comb begin
        valid_nxt_s     = 1'b0;
        crc_err_nxt_s   = 1'b0;
        frame_err_nxt_s = 1'b0;
        busy_nxt_s      = (state_r != IDLE);
        if (eval_r) begin
            if (!stop_r) begin
                frame_err_nxt_s = 1'b1;
            end else if (crc_rx_r != crc_r) begin
                crc_err_nxt_s = 1'b1;
            end else if ((dst_r == MY_ADDR) || (dst_r == BCAST_ADDR)) begin
                valid_nxt_s = 1'b1;
            end else begin
                valid_nxt_s = 1'b0;
            end
        end else begin
            valid_nxt_s = 1'b0;
        end
    end

    // Field shift registers, running CRC and the shared field down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= '0;
            src_r    <= 4'h0;
            dst_r    <= 4'h0;
            data_r   <= '0;
            crc_r    <= 4'h0;
            crc_rx_r <= 4'h0;
            stop_r   <= 1'b0;
            eval_r   <= 1'b0;
        end else begin
            eval_r <= (state_r == STOP);
            if (state_r == STOP) begin
                stop_r <= bus_in;
            end else begin
                stop_r <= stop_r;
            end
            case (state_r)
                IDLE: begin
                    if (!bus_in) begin
                        cnt_r <= CNT_W'(3);
                        crc_r <= 4'h0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                SRC: begin
                    src_r <= {src_r[2:0], bus_in};
                    crc_r <= crc4_step(crc_r, bus_in);
                    cnt_r <= (cnt_r == '0) ? CNT_W'(3) : cnt_r - CNT_W'(1);
                end
                DST: begin
                    dst_r <= {dst_r[2:0], bus_in};
                    crc_r <= crc4_step(crc_r, bus_in);
                    cnt_r <= (cnt_r == '0) ? CNT_W'(DATA_W - 1) : cnt_r - CNT_W'(1);
                end
                DATA: begin
                    data_r <= {data_r[DATA_W-2:0], bus_in};
                    crc_r  <= crc4_step(crc_r, bus_in);
                    cnt_r  <= (cnt_r == '0) ? CNT_W'(3) : cnt_r - CNT_W'(1);
                end
                CRC: begin
                    crc_rx_r <= {crc_rx_r[2:0], bus_in};
                    cnt_r    <= (cnt_r == '0) ? '0 : cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered outputs; payload and source hold until the next accepted frame
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid_r  <= 1'b0;
            rx_src_r    <= 4'h0;
            rx_data_r   <= '0;
            crc_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= valid_nxt_s;
            crc_err_r   <= crc_err_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            busy_r      <= busy_nxt_s;
            if (valid_nxt_s) begin
                rx_src_r  <= src_r;
                rx_data_r <= data_r;
            end else begin
                rx_src_r  <= rx_src_r;
                rx_data_r <= rx_data_r;
            end
        end
    end

    assign rx_valid  = rx_valid_r;
    assign rx_src    = rx_src_r;
    assign rx_data   = rx_data_r;
    assign crc_err   = crc_err_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Self-checking bench for bus_frame_receiver: table of frames plus hand sequences for
// latency, stop-bit error with a held-low bus, and reset in mid-frame.
module tb_bus_frame_receiver;

    logic        clock;
    logic        reset;
    logic        bus_in;
    logic        rx_valid;
    logic [3:0]  rx_src;
    logic [63:0] rx_data;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_v     = 0;
    int n_ce    = 0;
    int n_fe    = 0;
    logic prev_any = 1'b0;

    bus_frame_receiver #(.MY_ADDR(4'd1), .BCAST_ADDR(4'd15), .DATA_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus_in    (bus_in),
        .rx_valid  (rx_valid),
        .rx_src    (rx_src),
        .rx_data   (rx_data),
        .crc_err   (crc_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC over src, dst, data, MSB first
    function automatic logic [3:0] crc_model(input logic [3:0] s, input logic [3:0] d,
                                             input logic [63:0] dat);
        logic [71:0] m;
        logic [3:0]  c;
        logic        fb;
        m = {s, d, dat};
        c = 4'h0;
        for (int i = 71; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    // Pulse monitor: counts pulses and checks they are exclusive and single-cycle
    always @(negedge clock) begin
        if (rx_valid) n_v++;
        if (crc_err) n_ce++;
        if (frame_err) n_fe++;
        if (rx_valid || crc_err || frame_err) begin
            check("pulse_onehot_1cyc",
                  64'((32'(rx_valid) + 32'(crc_err) + 32'(frame_err) == 1) && !prev_any),
                  64'd1);
        end
        prev_any = rx_valid | crc_err | frame_err;
    end

    // Drives one 78-bit frame; rst_idx selects a bit position that also gets reset
    task automatic drive_frame(input logic [3:0] s, input logic [3:0] d, input logic [63:0] dat,
                               input logic [3:0] c, input logic stop, input int rst_idx);
        logic [77:0] f;
        f = {1'b0, s, d, dat, c, stop};
        for (int i = 77; i >= 0; i--) begin
            @(negedge clock);
            bus_in = f[i];
            reset  = (i == rst_idx);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus_in = 1'b1;
            reset  = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [63:0] data;
        logic [3:0]  crc;
        logic        stop;
        int          gap;
        logic        chk;
        int          exp_v;
        int          exp_ce;
        logic [3:0]  exp_src;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v0, ce0, fe0;

        // Cumulative expected counts are relative to the start of the table loop
        vecs[0] = '{4'h0, 4'h1, 64'h1, 4'h6, 1'b1, 3, 1'b1, 1, 0, 4'h0, 64'h1};
        vecs[1] = '{4'h0, 4'h1, 64'h1, 4'h5, 1'b1, 3, 1'b1, 1, 1, 4'h0, 64'h1};
        vecs[2] = '{4'h3, 4'h2, 64'h0, crc_model(4'h3, 4'h2, 64'h0), 1'b1, 0, 1'b0,
                    1, 1, 4'h0, 64'h1};
        vecs[3] = '{4'h3, 4'h1, 64'h0, crc_model(4'h3, 4'h1, 64'h0), 1'b1, 3, 1'b1,
                    2, 1, 4'h3, 64'h0};
        vecs[4] = '{4'h5, 4'hF, 64'hDEAD_BEEF_0123_4567,
                    crc_model(4'h5, 4'hF, 64'hDEAD_BEEF_0123_4567), 1'b1, 3, 1'b1,
                    3, 1, 4'h5, 64'hDEAD_BEEF_0123_4567};
        vecs[5] = '{4'h7, 4'h4, 64'h0F0F_0F0F_F0F0_F0F0,
                    crc_model(4'h7, 4'h4, 64'h0F0F_0F0F_F0F0_F0F0) ^ 4'h1, 1'b1, 3, 1'b1,
                    3, 2, 4'h5, 64'hDEAD_BEEF_0123_4567};
        vecs[6] = '{4'h9, 4'h6, 64'hA5A5_5A5A_C3C3_3C3C,
                    crc_model(4'h9, 4'h6, 64'hA5A5_5A5A_C3C3_3C3C), 1'b1, 3, 1'b1,
                    3, 2, 4'h5, 64'hDEAD_BEEF_0123_4567};

        reset  = 1'b1;
        bus_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        @(posedge clock); #1;
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_src", 64'(rx_src), 64'd0);
        check("rst_rx_data", rx_data, 64'd0);
        check("rst_crc_err", 64'(crc_err), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Latency: start sampled at edge N, pulse visible after edge N+78
        drive_frame(4'h0, 4'h1, 64'h0, 4'h5, 1'b1, -1);
        @(posedge clock); #1;
        check("lat_early_valid", 64'(rx_valid), 64'd0);
        check("lat_early_busy", 64'(busy), 64'd1);
        @(posedge clock); #1;
        check("lat_valid", 64'(rx_valid), 64'd1);
        check("lat_busy_drop", 64'(busy), 64'd0);
        check("lat_crc_err", 64'(crc_err), 64'd0);
        check("lat_frame_err", 64'(frame_err), 64'd0);
        check("lat_src", 64'(rx_src), 64'd0);
        check("lat_data", rx_data, 64'd0);
        @(posedge clock); #1;
        check("lat_valid_1cyc", 64'(rx_valid), 64'd0);
        idle(2);

        v0 = n_v; ce0 = n_ce; fe0 = n_fe;
        for (int k = 0; k < 7; k++) begin
            drive_frame(vecs[k].src, vecs[k].dst, vecs[k].data, vecs[k].crc, vecs[k].stop, -1);
            idle(vecs[k].gap);
            if (vecs[k].chk) begin
                @(posedge clock); #1;
                check($sformatf("vec%0d_valid_cnt", k), 64'(n_v - v0), 64'(vecs[k].exp_v));
                check($sformatf("vec%0d_crc_err_cnt", k), 64'(n_ce - ce0), 64'(vecs[k].exp_ce));
                check($sformatf("vec%0d_frame_err_cnt", k), 64'(n_fe - fe0), 64'd0);
                check($sformatf("vec%0d_src", k), 64'(rx_src), 64'(vecs[k].exp_src));
                check($sformatf("vec%0d_data", k), rx_data, vecs[k].exp_data);
            end
        end

        // Stop bit 0 with the bus held low afterwards
        v0 = n_v; fe0 = n_fe;
        drive_frame(4'h0, 4'h1, 64'h5555, crc_model(4'h0, 4'h1, 64'h5555), 1'b0, -1);
        @(posedge clock); #1;
        check("ferr_early", 64'(frame_err), 64'd0);
        @(posedge clock); #1;
        check("ferr_pulse", 64'(frame_err), 64'd1);
        check("ferr_busy", 64'(busy), 64'd1);
        check("ferr_no_valid", 64'(rx_valid), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        check("ferr_wait_hi_busy", 64'(busy), 64'd1);
        check("ferr_cnt", 64'(n_fe - fe0), 64'd1);
        @(negedge clock);
        bus_in = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        check("ferr_busy_release", 64'(busy), 64'd0);
        drive_frame(4'h2, 4'h1, 64'h1234, crc_model(4'h2, 4'h1, 64'h1234), 1'b1, -1);
        idle(3);
        @(posedge clock); #1;
        check("ferr_next_valid_cnt", 64'(n_v - v0), 64'd1);
        check("ferr_next_src", 64'(rx_src), 64'h2);
        check("ferr_next_data", rx_data, 64'h1234);

        // Reset on data bit 30; this frame's CRC is 4'hF so its tail holds no false start
        v0 = n_v; ce0 = n_ce; fe0 = n_fe;
        drive_frame(4'hC, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                    crc_model(4'hC, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 38);
        idle(3);
        @(posedge clock); #1;
        check("abort_valid_cnt", 64'(n_v - v0), 64'd0);
        check("abort_crc_err_cnt", 64'(n_ce - ce0), 64'd0);
        check("abort_frame_err_cnt", 64'(n_fe - fe0), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data_cleared", rx_data, 64'd0);
        drive_frame(4'h0, 4'hF, 64'h0, crc_model(4'h0, 4'hF, 64'h0), 1'b1, -1);
        idle(3);
        @(posedge clock); #1;
        check("bcast_valid_cnt", 64'(n_v - v0), 64'd1);
        check("bcast_err_cnt", 64'((n_ce - ce0) + (n_fe - fe0)), 64'd0);
        check("bcast_src", 64'(rx_src), 64'h0);
        check("bcast_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
